branch_ctl: RTL and testbench

Branch-resolution block that drives the program counter's `jump_en`/`target` inputs from the decoded branch opcode, registered ALU flags and its own return-address stack. It sits between the decoder and the program counter and closes the fetch loop. The program counter only jumps relative (`prog_ctr <= prog_ctr + target`), so this block converts every redirect into a signed offset, including call returns and halt. The halt case is encoded as offset 0.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_ctl_if.sv | 21 ++
 rtl/ret_stack.sv | 31 +++
 rtl/branch_ctl.sv | 46 ++++
 tb/tb_branch_ctl.sv | 98 +++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: branch opcodes, sizing constants and the assembler-generated offset LUT
package branch_pkg;
    localparam int D  = 12;
    localparam int LW = 4;
    localparam int SD = 4;
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_BZ   = 3'd2,
        BR_BNZ  = 3'd3,
        BR_BN   = 3'd4,
        BR_CALL = 3'd5,
        BR_RET  = 3'd6,
        BR_HALT = 3'd7
    } br_op_t;
    localparam logic [D-1:0] BR_LUT [2**LW] = '{
        12'h001, 12'h002, 12'h008, 12'h010, 12'h040, 12'hFF0, 12'h100, 12'h080,
        12'h004, 12'hFFC, 12'h020, 12'hFE0, 12'h200, 12'hE00, 12'h7FF, 12'h800
    };
endpackage

// File: rtl/branch_ctl_if.sv
// branch_ctl_if: decoder/ALU/PC bundle around branch_ctl; slave = branch_ctl, master = surrounding datapath
interface branch_ctl_if import branch_pkg::*; ;
    logic [D-1:0]  prog_ctr;
    br_op_t        br_op;
    logic [LW-1:0] br_idx;
    logic          flag_we;
    logic          alu_zero;
    logic          alu_neg;
    logic          jump_en;
    logic [D-1:0]  target;
    logic          done;
    logic          stk_err;
    modport master (
        output prog_ctr, br_op, br_idx, flag_we, alu_zero, alu_neg,
        input  jump_en, target, done, stk_err
    );
    modport slave (
        input  prog_ctr, br_op, br_idx, flag_we, alu_zero, alu_neg,
        output jump_en, target, done, stk_err
    );
endinterface

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO; ports clk, reset (async low), push/pop, din, dout (top entry), empty, full
module ret_stack #(
    parameter int D  = 12,
    parameter int SD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(SD + 1);
    localparam int AW = $clog2(SD);
    logic [PW-1:0] sp_q, sp_d;
    logic [D-1:0]  mem [SD];
    always_comb begin
        empty = sp_q == '0;
        full  = sp_q == PW'(SD);
        sp_d  = (push && !full) ? sp_q + PW'(1) : (pop && !empty) ? sp_q - PW'(1) : sp_q;
        dout  = mem[AW'(sp_q - PW'(1))];
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) sp_q <= '0;
        else        sp_q <= sp_d;
    // contents are left unreset: sp=0 makes stale entries unreachable
    always_ff @(posedge clk)
        if (push && !full) mem[AW'(sp_q)] <= din;
endmodule

// File: rtl/branch_ctl.sv
// branch_ctl: resolves branch opcodes into a relative PC redirect (jump_en/target); ports clk, reset (async low), bus (slave)
module branch_ctl import branch_pkg::*; (
    input  logic         clk,
    input  logic         reset,
    branch_ctl_if.slave  bus
);
    logic         z_q, z_d, n_q, n_d, done_q, done_d, err_q, err_d;
    logic         push, pop, empty, full, taken, hold;
    logic [D-1:0] dout;
    ret_stack #(.D(D), .SD(SD)) u_stk (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.prog_ctr + D'(1)),
        .dout  (dout),
        .empty (empty),
        .full  (full)
    );
    always_comb begin
        taken  = bus.br_op == BR_JMP
              || (bus.br_op == BR_BZ   && z_q)
              || (bus.br_op == BR_BNZ  && !z_q)
              || (bus.br_op == BR_BN   && n_q)
              || (bus.br_op == BR_CALL && !full)
              || (bus.br_op == BR_RET  && !empty);
        // halt (pending or latched) pins the PC with a taken zero offset
        hold   = done_q || bus.br_op == BR_HALT;
        push   = !done_q && bus.br_op == BR_CALL && !full;
        pop    = !done_q && bus.br_op == BR_RET && !empty;
        err_d  = err_q || (!done_q && ((bus.br_op == BR_CALL && full) || (bus.br_op == BR_RET && empty)));
        done_d = hold;
        z_d    = bus.flag_we ? bus.alu_zero : z_q;
        n_d    = bus.flag_we ? bus.alu_neg : n_q;
        bus.jump_en = reset && (hold || taken);
        // return offset is R - pc so the PC lands exactly on R modulo 2^D
        bus.target  = (!reset || hold || !taken) ? '0
                    : bus.br_op == BR_RET ? dout - bus.prog_ctr
                    : BR_LUT[bus.br_idx];
        bus.done    = done_q;
        bus.stk_err = err_q;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) {z_q, n_q, done_q, err_q} <= '0;
        else        {z_q, n_q, done_q, err_q} <= {z_d, n_d, done_d, err_d};
endmodule

// File: tb/tb_branch_ctl.sv
// tb_branch_ctl: directed self-checking bench for branch_ctl
module tb_branch_ctl;
    import branch_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    branch_ctl_if bus();
    branch_ctl dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input br_op_t op, input logic [3:0] idx, input logic [11:0] pc,
                         input logic fwe = 1'b0, input logic z = 1'b0, input logic n = 1'b0);
        @(negedge clk);
        bus.br_op = op; bus.br_idx = idx; bus.prog_ctr = pc;
        bus.flag_we = fwe; bus.alu_zero = z; bus.alu_neg = n;
        #1;
    endtask

    task automatic redirect(input string tag, input logic je, input logic [11:0] tgt);
        chk({tag, ".jump_en"}, 32'(bus.jump_en), 32'(je));
        chk({tag, ".target"}, 32'(bus.target), 32'(tgt));
    endtask

    initial begin
        bus.br_op = BR_JMP; bus.br_idx = 4'd3; bus.prog_ctr = 12'h005;
        bus.flag_we = 1'b0; bus.alu_zero = 1'b0; bus.alu_neg = 1'b0;
        #3;
        redirect("in_reset", 1'b0, 12'h000);
        chk("in_reset.done", 32'(bus.done), 0);
        chk("in_reset.stk_err", 32'(bus.stk_err), 0);
        chk("in_reset.sp", 32'(dut.u_stk.sp_q), 0);
        @(negedge clk); reset = 1'b1;
        drive(BR_NONE, 4'd3, 12'h005);            redirect("none", 1'b0, 12'h000);
        drive(BR_JMP, 4'd3, 12'h005);             redirect("jmp3", 1'b1, 12'h010);
        drive(BR_NONE, 4'd0, 12'h006, 1'b1, 1'b1); redirect("flag_z", 1'b0, 12'h000);
        drive(BR_BZ, 4'd3, 12'h007, 1'b1, 1'b0);  redirect("bz_old_flag", 1'b1, 12'h010);
        drive(BR_BZ, 4'd3, 12'h017);              redirect("bz_clear", 1'b0, 12'h000);
        drive(BR_BNZ, 4'd2, 12'h018);             redirect("bnz", 1'b1, 12'h008);
        drive(BR_BN, 4'd2, 12'h020, 1'b1, 1'b0, 1'b1); redirect("bn_old", 1'b0, 12'h000);
        drive(BR_BN, 4'd5, 12'h021);              redirect("bn", 1'b1, 12'hFF0);
        drive(BR_CALL, 4'd4, 12'h020);            redirect("call", 1'b1, 12'h040);
        drive(BR_RET, 4'd0, 12'h065);             redirect("ret", 1'b1, 12'hFBC);
        drive(BR_CALL, 4'd0, 12'h100);            redirect("call1", 1'b1, 12'h001);
        drive(BR_CALL, 4'd0, 12'h200);            redirect("call2", 1'b1, 12'h001);
        drive(BR_CALL, 4'd0, 12'h300);            redirect("call3", 1'b1, 12'h001);
        drive(BR_CALL, 4'd0, 12'h400);            redirect("call4", 1'b1, 12'h001);
        chk("pre_ovf.stk_err", 32'(bus.stk_err), 0);
        drive(BR_CALL, 4'd0, 12'h450);            redirect("call5_full", 1'b0, 12'h000);
        drive(BR_RET, 4'd0, 12'h500);
        chk("ovf.stk_err", 32'(bus.stk_err), 1);
        chk("ovf.sp", 32'(dut.u_stk.sp_q), 4);
        redirect("ret4", 1'b1, 12'hF01);
        drive(BR_RET, 4'd0, 12'h500);             redirect("ret3", 1'b1, 12'hE01);
        drive(BR_RET, 4'd0, 12'h500);             redirect("ret2", 1'b1, 12'hD01);
        drive(BR_RET, 4'd0, 12'h500);             redirect("ret1", 1'b1, 12'hC01);
        drive(BR_CALL, 4'd1, 12'hFFF);            redirect("call_wrap", 1'b1, 12'h002);
        drive(BR_RET, 4'd0, 12'h001);             redirect("ret_wrap", 1'b1, 12'hFFF);
        drive(BR_NONE, 4'd0, 12'h000);
        chk("unwound.sp", 32'(dut.u_stk.sp_q), 0);
        #1; reset = 1'b0; #1;
        chk("rst1.stk_err", 32'(bus.stk_err), 0);
        @(negedge clk); reset = 1'b1;
        drive(BR_RET, 4'd0, 12'h010);             redirect("ret_empty", 1'b0, 12'h000);
        drive(BR_NONE, 4'd0, 12'h011);
        chk("ret_empty.stk_err", 32'(bus.stk_err), 1);
        #1; reset = 1'b0; #1;
        @(negedge clk); reset = 1'b1;
        drive(BR_CALL, 4'd0, 12'h010);            redirect("hcall1", 1'b1, 12'h001);
        drive(BR_CALL, 4'd0, 12'h020);            redirect("hcall2", 1'b1, 12'h001);
        drive(BR_HALT, 4'd3, 12'h030);            redirect("halt", 1'b1, 12'h000);
        chk("halt.done_before", 32'(bus.done), 0);
        drive(BR_JMP, 4'd3, 12'h030);             redirect("done_jmp", 1'b1, 12'h000);
        chk("done.done", 32'(bus.done), 1);
        drive(BR_CALL, 4'd4, 12'h030);            redirect("done_call", 1'b1, 12'h000);
        drive(BR_RET, 4'd0, 12'h030);             redirect("done_ret", 1'b1, 12'h000);
        chk("done.sp", 32'(dut.u_stk.sp_q), 2);
        chk("done.stk_err", 32'(bus.stk_err), 0);
        #2; reset = 1'b0; #1;
        redirect("async_rst", 1'b0, 12'h000);
        chk("async_rst.done", 32'(bus.done), 0);
        chk("async_rst.sp", 32'(dut.u_stk.sp_q), 0);
        @(negedge clk); reset = 1'b1;
        drive(BR_RET, 4'd0, 12'h040);             redirect("post_rst_ret", 1'b0, 12'h000);
        drive(BR_NONE, 4'd0, 12'h041);
        chk("post_rst_ret.stk_err", 32'(bus.stk_err), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
